// File: rtl/serial_adder.sv
// Bit-serial adder: captures a, b and cin on start, adds one bit per cycle LSB first, registers sum/cout.
// Latency WIDTH+1 edges from the accepting edge to the done cycle; start is ignored unless IDLE.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             s_bit;
    logic             c_next;
    logic [WIDTH-1:0] res_shift;

    always_comb begin
        s_bit     = a_q[0] ^ b_q[0] ^ carry_q;
        c_next    = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
        res_shift = {s_bit, res_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = res_shift;
                carry_d = c_next;
                cnt_d   = cnt_q + CW'(1);
                // The final bit is folded straight into sum so the result lands as DONE is entered.
                if (cnt_q == LAST_BIT) begin
                    sum_d   = res_shift;
                    cout_d  = c_next;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8 and WIDTH=2 instances checked every cycle against a
// phase-level arithmetic model, with literal results pinning the directed cases.
module tb_serial_adder;

    localparam int W8 = 8;
    localparam int W2 = 2;
    localparam logic [8:0] LIT8 [7] = '{9'h046, 9'h100, 9'h101, 9'h096, 9'h081, 9'h100, 9'h0FF};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start8, cin8, cout8, busy8, done8;
    logic [7:0] a8, b8, sum8;
    logic       start2, cin2, cout2, busy2, done2;
    logic [1:0] a2, b2, sum2;

    logic b2b = 1'b0;
    int   checks = 0;
    int   errors = 0;

    serial_adder #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .sum(sum8), .cout(cout8), .busy(busy8), .done(done8)
    );

    serial_adder #(.WIDTH(W2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .sum(sum2), .cout(cout2), .busy(busy2), .done(done2)
    );

    // Model: phase 0 idle, 1..W busy, W+1 done; the result is plain a+b+cin taken at acceptance.
    int         m8_ph;
    logic [8:0] m8_pend;
    logic [7:0] m8_sum;
    logic       m8_cout;
    int         m2_ph;
    logic [2:0] m2_pend;
    logic [1:0] m2_sum;
    logic       m2_cout;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m8_ph <= 0; m8_pend <= '0; m8_sum <= '0; m8_cout <= 1'b0;
        end else if (m8_ph == 0) begin
            if (start8) begin
                m8_ph   <= 1;
                m8_pend <= {1'b0, a8} + {1'b0, b8} + 9'(cin8);
            end
        end else if (m8_ph == W8) begin
            m8_ph <= W8 + 1;
            {m8_cout, m8_sum} <= m8_pend;
        end else if (m8_ph == W8 + 1) begin
            m8_ph <= 0;
        end else begin
            m8_ph <= m8_ph + 1;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m2_ph <= 0; m2_pend <= '0; m2_sum <= '0; m2_cout <= 1'b0;
        end else if (m2_ph == 0) begin
            if (start2) begin
                m2_ph   <= 1;
                m2_pend <= {1'b0, a2} + {1'b0, b2} + 3'(cin2);
            end
        end else if (m2_ph == W2) begin
            m2_ph <= W2 + 1;
            {m2_cout, m2_sum} <= m2_pend;
        end else if (m2_ph == W2 + 1) begin
            m2_ph <= 0;
        end else begin
            m2_ph <= m2_ph + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, got, exp, $time);
        end
    endtask

    int cyc       = 0;
    int n_done8   = 0;
    int last_b2b  = -1;

    initial begin
        forever begin
            @(negedge clk or posedge rst);
            #1;
            chk("busy8", 32'(busy8), 32'(m8_ph >= 1 && m8_ph <= W8));
            chk("done8", 32'(done8), 32'(m8_ph == W8 + 1));
            chk("sum8",  32'(sum8),  32'(m8_sum));
            chk("cout8", 32'(cout8), 32'(m8_cout));
            chk("busy2", 32'(busy2), 32'(m2_ph >= 1 && m2_ph <= W2));
            chk("done2", 32'(done2), 32'(m2_ph == W2 + 1));
            chk("sum2",  32'(sum2),  32'(m2_sum));
            chk("cout2", 32'(cout2), 32'(m2_cout));
            if (!clk) begin
                cyc++;
                if (m8_ph == W8 + 1) begin
                    if (n_done8 < 7)
                        chk("model_lit8", 32'({m8_cout, m8_sum}), 32'(LIT8[n_done8]));
                    n_done8++;
                end
                if (b2b && done8 === 1'b1) begin
                    if (last_b2b >= 0)
                        chk("b2b_spacing", 32'(cyc - last_b2b), 32'(W8 + 2));
                    last_b2b = cyc;
                end
            end
        end
    end

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c);
        @(negedge clk);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        repeat (W8 + 2) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        run8(8'h12, 8'h34, 1'b0);
        run8(8'hFF, 8'h01, 1'b0);
        run8(8'h80, 8'h80, 1'b1);

        // A second start in RUN cycle 3 must be ignored.
        @(negedge clk);
        a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (W8) @(negedge clk);

        // Reset in RUN cycle 4 aborts the addition and clears the previous result.
        @(negedge clk);
        a8 = 8'h33; b8 = 8'h44; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run8(8'h7F, 8'h01, 1'b1);

        // start held high across two operand sets.
        b2b = 1'b1;
        @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        a8 = 8'h0F; b8 = 8'hF0; cin8 = 1'b0;
        repeat (12) @(negedge clk);
        start8 = 1'b0;
        repeat (12) @(negedge clk);
        b2b = 1'b0;

        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            a2 = i[1:0]; b2 = i[3:2]; cin2 = i[4]; start2 = 1'b1;
            @(negedge clk);
            start2 = 1'b0;
            a2 = 2'($urandom); b2 = 2'($urandom); cin2 = 1'($urandom);
            repeat (4) @(negedge clk);
        end

        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            start8 = ($urandom_range(0, 3) == 0);
            a2 = 2'($urandom); b2 = 2'($urandom); cin2 = 1'($urandom);
            start2 = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 149) == 0);
        end
        @(negedge clk);
        rst = 1'b0; start8 = 1'b0; start2 = 1'b0;
        repeat (W8 + 3) @(negedge clk);

        if (n_done8 < 7) begin
            $display("FAIL directed_done_count got %0d want >= 7", n_done8);
        end
        $display("CHECKS %0d ERRORS %0d", checks, (n_done8 < 7) ? errors + 1 : errors);
        $finish;
    end

endmodule
